// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - funct3 width/sign encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - FSM state enum lsu_state_e {IDLE, BUS, DONE}
//   - wstrb_f: byte-enable pattern for a store of a given width at a byte offset
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Store byte enables; any funct3 other than byte/half is a full word.
  function automatic logic [3:0] wstrb_f(input logic [2:0] funct3, input logic [1:0] lo);
    case (funct3)
      F3_B:    wstrb_f = 4'b0001 << lo;
      F3_H:    wstrb_f = lo[1] ? 4'b1100 : 4'b0011;
      default: wstrb_f = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extraction: selects the addressed byte/halfword lane of a bus word
// and sign- or zero-extends it to XLEN.
//   word   : raw bus read word
//   lo     : byte offset within the word (addr[1:0])
//   funct3 : load width/sign field; unsupported encodings return the full word
//   result : extended load value
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select by right shift; halfwords only look at addr[1].
  assign byte_v = 8'(word >> {lo, 3'b000});
  assign half_v = 16'(word >> {lo[1], 4'b0000});

  always_comb begin
    result = word;
    case (funct3)
      F3_B:    result = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   result = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    result = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   result = {{(XLEN-16){1'b0}}, half_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: one valid/ready bus transaction per request,
// stalling the pipeline until completion.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_*                 : request from MEM stage (held while stall=1 and through done)
//   stall                 : combinational pipeline freeze
//   done                  : one-cycle completion pulse
//   rdata                 : extended load result, held until the next load completes
//   misalign              : misaligned-access flag, pulses with done
//   mem_*                 : data-memory bus (word-aligned address, byte strobes)
// Build option: LSU_MISALIGN_TRAP_EN - misaligned half/word accesses skip the
// bus and complete immediately with misalign=1; otherwise low address bits
// beyond the access width are ignored and misalign is tied 0.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            misalign,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUS  = BUS;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]      state, state_nxt;
  logic            we_q, we_nxt;
  logic [2:0]      f3_q, f3_nxt;
  logic [1:0]      lo_q, lo_nxt;
  logic            done_nxt, misalign_nxt, mem_valid_nxt, mem_we_nxt;
  logic [XLEN-1:0] rdata_nxt, mem_addr_nxt, mem_wdata_nxt;
  logic [3:0]      mem_wstrb_nxt;
  logic [XLEN-1:0] ld_result;
  logic [XLEN-1:0] wdata_rep;
  logic            req_misalign;

  lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
    .word   (mem_rdata),
    .lo     (lo_q),
    .funct3 (f3_q),
    .result (ld_result)
  );

  // Replicate store data across all lanes it may land in.
  always_comb begin
    case (req_funct3)
      F3_B:    wdata_rep = {(XLEN/8){req_wdata[7:0]}};
      F3_H:    wdata_rep = {(XLEN/16){req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic is_byte, is_half;
  // BU/HU encodings are only byte/half for loads; stores treat them as words.
  assign is_byte = (req_funct3 == F3_B) || (!req_we && (req_funct3 == F3_BU));
  assign is_half = (req_funct3 == F3_H) || (!req_we && (req_funct3 == F3_HU));
  assign req_misalign = is_half ? req_addr[0] : (!is_byte && (req_addr[1:0] != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt     = state;
    we_nxt        = we_q;
    f3_nxt        = f3_q;
    lo_nxt        = lo_q;
    done_nxt      = 1'b0;
    misalign_nxt  = 1'b0;
    rdata_nxt     = rdata;
    mem_valid_nxt = mem_valid;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wstrb_nxt = mem_wstrb;
    mem_wdata_nxt = mem_wdata;
    stall         = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          we_nxt = req_we;
          f3_nxt = req_funct3;
          lo_nxt = req_addr[1:0];
          if (req_misalign) begin
            state_nxt    = ST_DONE;
            done_nxt     = 1'b1;
            misalign_nxt = 1'b1;
          end else begin
            state_nxt     = ST_BUS;
            mem_valid_nxt = 1'b1;
            mem_we_nxt    = req_we;
            mem_addr_nxt  = {req_addr[XLEN-1:2], 2'b00};
            mem_wstrb_nxt = req_we ? wstrb_f(req_funct3, req_addr[1:0]) : 4'b0000;
            mem_wdata_nxt = req_we ? wdata_rep : '0;
          end
        end
      end
      ST_BUS: begin
        stall = 1'b1;
        if (mem_ready) begin
          state_nxt     = ST_DONE;
          mem_valid_nxt = 1'b0;
          done_nxt      = 1'b1;
          if (!we_q) rdata_nxt = ld_result;
        end
      end
      ST_DONE: begin
        // Requester is still presenting the completing op; do not restart.
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      lo_q      <= 2'd0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      rdata     <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      we_q      <= we_nxt;
      f3_q      <= f3_nxt;
      lo_q      <= lo_nxt;
      done      <= done_nxt;
      misalign  <= misalign_nxt;
      rdata     <= rdata_nxt;
      mem_valid <= mem_valid_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wstrb <= mem_wstrb_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized loads/stores
// checked against a behavioural byte-lane model.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int          n_chk;
  int          n_fail;
  int          bus_txn;
  int          exp_txn;
  logic [31:0] exp_rdata;

  lsu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .misalign   (misalign),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed bus handshakes.
  always @(posedge clk) begin
    if (rst_n && mem_valid && mem_ready) bus_txn++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_bytes(input bit we, input bit [2:0] f3);
    if (f3 == 3'd0 || (!we && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (!we && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic int lane_off(input int n, input logic [31:0] addr);
    if (n == 1) return int'(addr % 4);
    if (n == 2) return int'(addr % 4) & 2;
    return 0;
  endfunction

  function automatic bit model_mis(input int n, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    return (n == 2 && (addr % 2) != 0) || (n == 4 && (addr % 4) != 0);
`else
    return (n < 0) && (addr == 0);
`endif
  endfunction

  function automatic logic [31:0] model_strb(input int n, input logic [31:0] addr);
    int m;
    m = ((1 << n) - 1) << lane_off(n, addr);
    return 32'(m & 15);
  endfunction

  function automatic logic [31:0] model_wdata(input int n, input logic [31:0] wd);
    logic [31:0] r;
    r = 0;
    for (int lane = 0; lane < 4; lane++) begin
      r = r | (((wd >> (8 * (lane % n))) & 32'hFF) << (8 * lane));
    end
    return r;
  endfunction

  function automatic logic [31:0] model_load(input bit [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int n;
    logic [31:0] v;
    n = acc_bytes(1'b0, f3);
    v = word >> (8 * lane_off(n, addr));
    if (n == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (n == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // ---------------- one complete operation ----------------
  // Presents the request, answers the bus after dly wait cycles and checks
  // every cycle up to the IDLE cycle following DONE (req_valid left high).
  task automatic do_op(input bit we, input bit [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int dly, input logic [31:0] word);
    int n;
    int st;
    bit mis;
    n   = acc_bytes(we, f3);
    mis = model_mis(n, addr);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    mem_ready  = 1'b0;
    #1;
    chk("stall_accept", 32'(stall), 32'd1);
    st = 1;
    @(posedge clk); #1;
    if (mis) begin
      chk("mis_done", 32'(done), 32'd1);
      chk("mis_flag", 32'(misalign), 32'd1);
      chk("mis_no_bus", 32'(mem_valid), 32'd0);
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_rdata_held", rdata, exp_rdata);
    end else begin
      chk("bus_valid", 32'(mem_valid), 32'd1);
      chk("bus_we", 32'(mem_we), 32'(we));
      chk("bus_addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("bus_wstrb", 32'(mem_wstrb), we ? model_strb(n, addr) : 32'd0);
      if (we) chk("bus_wdata", mem_wdata, model_wdata(n, wd));
      chk("early_done", 32'(done), 32'd0);
      for (int i = 0; i <= dly; i++) begin
        @(negedge clk);
        mem_ready = (i == dly);
        mem_rdata = (i == dly) ? word : $urandom();
        #1;
        st += int'(stall);
        @(posedge clk); #1;
        if (i < dly) begin
          chk("wait_valid", 32'(mem_valid), 32'd1);
          chk("wait_done", 32'(done), 32'd0);
          chk("wait_addr", mem_addr, addr & 32'hFFFF_FFFC);
        end
      end
      exp_txn++;
      if (!we) exp_rdata = model_load(f3, addr, word);
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_misalign", 32'(misalign), 32'd0);
      chk("done_valid_low", 32'(mem_valid), 32'd0);
      chk("rdata", rdata, exp_rdata);
    end
    chk("stall_cycles", 32'(st), mis ? 32'd1 : 32'(dly + 2));
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("stall_in_done", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("done_single", 32'(done), 32'd0);
    chk("no_restart", 32'(mem_valid), 32'd0);
    chk("mis_cleared", 32'(misalign), 32'd0);
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    int base;
    n_chk      = 0;
    n_fail     = 0;
    bus_txn    = 0;
    exp_txn    = 0;
    exp_rdata  = 32'd0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_stall", 32'(stall), 32'd0);

    // LBU, immediate ready
    do_op(1'b0, 3'd4, 32'h0000_1003, 32'd0, 0, 32'h80FF_1234);
    chk("lbu_value", rdata, 32'h0000_0080);
    // LB / LH with three wait cycles
    do_op(1'b0, 3'd0, 32'h0000_1003, 32'd0, 3, 32'h80FF_1234);
    chk("lb_value", rdata, 32'hFFFF_FF80);
    do_op(1'b0, 3'd1, 32'h0000_1002, 32'd0, 3, 32'h80FF_1234);
    chk("lh_value", rdata, 32'hFFFF_80FF);
    // Stores leave rdata alone
    do_op(1'b1, 3'd0, 32'h0000_2001, 32'hAABB_CCDD, 0, 32'd0);
    do_op(1'b1, 3'd1, 32'h0000_2002, 32'hAABB_CCDD, 1, 32'd0);
    chk("store_keeps_rdata", rdata, 32'hFFFF_80FF);
    // Back-to-back LW then SW
    base = bus_txn;
    do_op(1'b0, 3'd2, 32'h0000_3000, 32'd0, 0, 32'h1357_9BDF);
    do_op(1'b1, 3'd2, 32'h0000_3004, 32'h0BAD_F00D, 0, 32'd0);
    chk("b2b_txn", 32'(bus_txn - base), 32'd2);
    // Word access at addr 0x3002
    do_op(1'b0, 3'd2, 32'h0000_3002, 32'd0, 0, 32'hCAFE_BABE);
    go_idle();

    // Reset asserted while the bus is busy
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_4000;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(mem_valid), 32'd1);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    exp_rdata = 32'd0;
    chk("midrst_valid", 32'(mem_valid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rdata", rdata, exp_rdata);
    chk("midrst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(mem_valid), 32'd0);

    // Randomized operations, including unsupported funct3 encodings
    for (int k = 0; k < 60; k++) begin
      do_op(1'($urandom()), 3'($urandom()), $urandom(), $urandom(),
            int'($urandom_range(0, 3)), $urandom());
      if ($urandom_range(0, 3) == 0) begin
        go_idle();
        @(posedge clk); #1;
        chk("idle_gap_valid", 32'(mem_valid), 32'd0);
      end
    end
    go_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("bus_txn_total", 32'(bus_txn), 32'(exp_txn));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit for the MEM stage of the RV32I core.
- Runs one data-memory transaction per request over a valid/ready bus and stalls the pipeline until the transaction completes.
- Produces sign- or zero-extended load data; this is the read-data input of the writeback result select.
- Stores produce byte strobes and lane-replicated write data.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  MEM stage holds a load or store.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign field: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data (rs2).
- stall  out  1  freezes the pipeline (combinational).
- done  out  1  one-cycle completion pulse.
- rdata  out  XLEN  extended load result (registered).
- misalign  out  1  misaligned-access flag (see Optional Feature).
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus accept/complete; mem_rdata is valid in the same cycle.
- mem_we  out  1  bus write.
- mem_addr  out  XLEN  word-aligned address, {req_addr[31:2], 2'b00}.
- mem_wstrb  out  4  byte enables; 0 for loads.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_rdata  in  XLEN  bus read word.

Behaviour:
- States: IDLE, BUS, DONE. Reset state is IDLE.
- Reset values: mem_valid=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, rdata=0, done=0, misalign=0.
- IDLE:
  - If req_valid=1, register the request fields, drive the bus outputs from them, and go to BUS.
  - stall = req_valid.
- BUS:
  - mem_valid=1; all mem_* outputs held stable.
  - stall=1.
  - When mem_ready=1: capture the extended load (loads only) into rdata, then go to DONE.
  - Waits indefinitely; there is no timeout.
- DONE:
  - done=1, stall=0; the pipeline advances this cycle.
  - req_valid is ignored in this cycle (the requester is still presenting the completing op).
  - Always returns to IDLE.
- Requester rule: req_* must be held stable while stall=1 and through the DONE cycle.
- Latency: with mem_ready=1 on the first BUS cycle, done asserts 2 cycles after the accepting IDLE cycle. Each wait cycle adds 1. Back-to-back operations cost 3 cycles each.
- Store encoding:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = wdata unchanged.
- Load extract:
  - Shift mem_rdata right by 8*addr[1:0] for byte accesses, or by 16*addr[1] for halfword accesses.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- rdata holds its value until the next load completes. Stores leave rdata unchanged.
- Unsupported funct3 (load 3/6/7, store 3..7) is treated as a word access.
- Reset asserted mid-BUS: next edge goes to IDLE with mem_valid=0. The transaction is abandoned and the bus must tolerate this.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, is misaligned.
  - A misaligned request goes IDLE→DONE with no bus transaction (mem_valid stays 0).
  - misalign=1 together with done; rdata is unchanged.
- Undefined:
  - misalign is tied 0.
  - Low address bits not used by the access width are ignored (halfword uses addr[1] only; word uses none).

Decomposition:
- lsu_pkg holds:
  - The funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The state enum lsu_state_e {IDLE, BUS, DONE}.
  - A function computing wstrb from funct3 and addr[1:0].
- One combinational sub-module, lsu_load_ext, maps (mem_rdata, addr[1:0], funct3) to the extended XLEN result.

Test Plan:
- Reset then idle → all outputs 0, stall=0; assert rst_n low during BUS → mem_valid=0 after the next edge, state IDLE.
- LBU, addr=0x1003, mem_rdata=0x80FF_1234 on first-cycle mem_ready → mem_addr=0x1000, done 2 cycles after accept, rdata=0x0000_0080.
- LB and LH against the same word, with mem_ready delayed 3 cycles:
  - LB addr=0x1003 → rdata=0xFFFF_FF80.
  - LH addr=0x1002 → rdata=0xFFFF_80FF.
  - stall=1 for 5 cycles.
- SB addr=0x2001, wdata=0xAABB_CCDD → mem_we=1, wstrb=4'b0010, mem_wdata=0xDDDD_DDDD; SH addr=0x2002 → wstrb=4'b1100, mem_wdata=0xCCDD_CCDD.
- Back-to-back LW then SW, with the requester changing req_* the cycle after DONE → two distinct bus transactions; req_valid in the DONE cycle does not start a third.
- LW addr=0x3002:
  - With LSU_MISALIGN_TRAP_EN: no mem_valid; done and misalign assert 1 cycle after accept.
  - Without it: bus transaction at mem_addr=0x3000, misalign=0.
